sha256_blk_sequencer: RTL
=========================

Name: sha256_blk_sequencer

Overview:
- Sequences the SHA256 hash core on behalf of the register bank.
- Drains 32-bit message words from the SHA256 input FIFO and assembles each 512-bit block.
- Launches the core once per block, choosing initial hash vs chained hash, and tracks completion, block count, timeout and errors for the SHA256 status register.
- Sits between the regs module (control/status, FIFO) and the SHA256 compression core.

Parameters:
- AUTO_START, 1: 1 = launch each block as soon as 16 words are buffered; 0 = also wait for ctrl_start_i.
- TIMEOUT_CYC, 255: maximum cycles from core_start_o to core_done_i before an error is flagged; range 1..65535.
- CNT_W, 16: width of the block counter.

Ports:
- clk_100mhz  in  1  system clock, 100 MHz
- rstn_i  in  1  asynchronous active-low reset
- ctrl_reset_i  in  1  synchronous soft reset (SHA256 control bit 0)
- ctrl_start_i  in  1  start request (SHA256 control bit 1); level, edge-detected internally
- fifo_data_i  in  32  FIFO head word (first-word-fall-through)
- fifo_empty_i  in  1  FIFO empty
- fifo_rd_o  out  1  FIFO pop strobe
- core_blk_o  out  512  message block; W0 in [511:480], W15 in [31:0]
- core_init_o  out  1  1 = use initial H0..H7; 0 = chain from the previous digest
- core_start_o  out  1  one-cycle start pulse
- core_busy_i  in  1  core busy
- core_done_i  in  1  one-cycle completion pulse
- sts_busy_o  out  1  block launched, result pending
- sts_valid_o  out  1  digest of the last block is valid
- sts_full_o  out  1  16 words buffered, not yet launched
- sts_err_o  out  1  sticky error
- blk_cnt_o  out  CNT_W  number of completed blocks
- word_cnt_o  out  5  words buffered in the current block, 0..16

Behaviour:
- Reset state (rstn_i low, asynchronous): all outputs 0, core_blk_o 0, state COLLECT, first-block flag 1, start-pending 0.
- ctrl_reset_i high has the same effect synchronously, on the next clock edge.
  - ctrl_reset_i wins over every simultaneous event.
- States and transitions:
  - COLLECT:
    - fifo_rd_o = !fifo_empty_i && word_cnt < 16 (combinational).
    - Each pop shifts fifo_data_i into core_blk_o from the bottom, so the first word ends at [511:480]; word_cnt increments.
    - On the pop that makes word_cnt 16, go to FULL next cycle.
    - An empty FIFO stalls indefinitely; gaps between words are allowed.
  - FULL:
    - sts_full_o = 1; no pops.
    - Go to START when (AUTO_START || start_pend) && !core_busy_i.
  - START:
    - core_start_o = 1 for exactly one cycle; core_init_o = first-block flag in the same cycle.
    - start_pend cleared, sts_valid_o cleared, timeout counter loaded; go to WAIT.
  - WAIT:
    - sts_busy_o = 1; the timeout counter decrements each cycle.
    - On core_done_i: go to DONE.
    - On timeout reaching 0 without done: sts_err_o set, go to COLLECT with word_cnt 0, first-block flag unchanged, sts_valid_o stays 0.
  - DONE (1 cycle):
    - sts_valid_o set, blk_cnt_o incremented (wraps at 2^CNT_W), first-block flag cleared.
    - word_cnt cleared; go to COLLECT.
- Latency: 16th pop in cycle N gives FULL in N+1 and core_start_o in N+2 at the earliest (AUTO_START=1, core idle).
  - core_done_i in cycle M gives sts_valid_o and blk_cnt_o updated in M+1, and the first new pop possible in M+2.
- start_pend:
  - Set by a rising edge of ctrl_start_i while in COLLECT or FULL.
  - A rising edge in START, WAIT or DONE is ignored and sets sts_err_o.
- A rising edge of ctrl_start_i in COLLECT with word_cnt < 16 is held pending and is not an error.
- core_done_i outside WAIT is ignored, e.g. a late done after a soft reset or timeout.
- If core_busy_i is still high after a soft reset, FULL holds until it drops.
- sts_err_o clears only on reset or ctrl_reset_i.

Test Plan:
- Reset, then 16 pops of 0x00000000 except word 0 = 0x80000000 → core_start_o one cycle at N+2, core_init_o=1, core_blk_o[511:480]=0x80000000, rest 0; done after 64 cycles → sts_valid_o=1, blk_cnt_o=1.
- Two consecutive 16-word blocks, words 0x00000001..0x00000010 → second start has core_init_o=0, core_blk_o[31:0]=0x00000010, blk_cnt_o=2.
- AUTO_START=0: 16 words loaded → sts_full_o=1 and no start for 100 cycles; ctrl_start_i rising → core_start_o 2 cycles later.
- FIFO empty for 20 cycles after word 7 → fifo_rd_o=0, word_cnt_o=8 held; words 8..15 then complete the block normally.
- Core never asserts done, TIMEOUT_CYC=10 → sts_err_o=1 eleven cycles after start, word_cnt_o=0; a late core_done_i leaves blk_cnt_o unchanged.
- ctrl_reset_i in WAIT → all status 0, blk_cnt_o=0; next block starts with core_init_o=1.

Source files
------------

// File: rtl/sha256_blk_sequencer.sv
// SHA256 block sequencer: gathers 16 FIFO words into a 512-bit block, launches the
// compression core (initial or chained hash) and reports busy/valid/full/error/count status.
`timescale 1ns/1ps
module sha256_blk_sequencer #(
    parameter bit AUTO_START  = 1'b1,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk_100mhz,
    input  logic             rstn_i,
    input  logic             ctrl_reset_i,
    input  logic             ctrl_start_i,
    input  logic [31:0]      fifo_data_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_o,
    output logic [511:0]     core_blk_o,
    output logic             core_init_o,
    output logic             core_start_o,
    input  logic             core_busy_i,
    input  logic             core_done_i,
    output logic             sts_busy_o,
    output logic             sts_valid_o,
    output logic             sts_full_o,
    output logic             sts_err_o,
    output logic [CNT_W-1:0] blk_cnt_o,
    output logic [4:0]       word_cnt_o
);
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_FULL,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [511:0]       r_blk;
    logic [4:0]         r_word_cnt;
    logic               r_first;
    logic               r_start_pend;
    logic               r_start_d;
    logic               r_valid;
    logic               r_err;
    logic [CNT_W-1:0]   r_blk_cnt;
    logic [15:0]        r_tmo;
    logic               w_pop;
    logic               w_start_rise;
    logic               w_tmo_expire;

    assign w_start_rise = ctrl_start_i & ~r_start_d;

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_tmo_expire = 1'b0;
        case (r_state)
            S_COLLECT: begin
                w_pop = !fifo_empty_i && (r_word_cnt < 5'd16);
                if (w_pop && (r_word_cnt == 5'd15))
                    w_state_nxt = S_FULL;
            end
            S_FULL: begin
                if ((AUTO_START || r_start_pend) && !core_busy_i)
                    w_state_nxt = S_START;
            end
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // A done in the last allowed cycle still counts as a completion.
                if (core_done_i) begin
                    w_state_nxt = S_DONE;
                end else if (r_tmo <= 16'd1) begin
                    w_tmo_expire = 1'b1;
                    w_state_nxt  = S_COLLECT;
                end
            end
            S_DONE:  w_state_nxt = S_COLLECT;
            default: w_state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i)
            r_state <= S_COLLECT;
        else if (ctrl_reset_i)
            r_state <= S_COLLECT;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            r_blk        <= '0;
            r_word_cnt   <= '0;
            r_first      <= 1'b1;
            r_start_pend <= 1'b0;
            r_start_d    <= 1'b0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_blk_cnt    <= '0;
            r_tmo        <= '0;
        end else if (ctrl_reset_i) begin
            r_blk        <= '0;
            r_word_cnt   <= '0;
            r_first      <= 1'b1;
            r_start_pend <= 1'b0;
            // Keep tracking the level so a start held across the soft reset is not a new edge.
            r_start_d    <= ctrl_start_i;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_blk_cnt    <= '0;
            r_tmo        <= '0;
        end else begin
            r_start_d <= ctrl_start_i;
            if (w_start_rise) begin
                if ((r_state == S_COLLECT) || (r_state == S_FULL))
                    r_start_pend <= 1'b1;
                else
                    r_err <= 1'b1;
            end
            case (r_state)
                S_COLLECT: begin
                    if (w_pop) begin
                        r_blk      <= {r_blk[479:0], fifo_data_i};
                        r_word_cnt <= r_word_cnt + 5'd1;
                    end
                end
                S_START: begin
                    r_start_pend <= 1'b0;
                    r_valid      <= 1'b0;
                    r_tmo        <= TMO_LOAD;
                end
                S_WAIT: begin
                    if (core_done_i) begin
                        r_valid   <= 1'b1;
                        r_blk_cnt <= r_blk_cnt + CNT_W'(1);
                        r_first   <= 1'b0;
                    end else if (w_tmo_expire) begin
                        r_err      <= 1'b1;
                        r_word_cnt <= '0;
                    end else begin
                        r_tmo <= r_tmo - 16'd1;
                    end
                end
                S_DONE:  r_word_cnt <= '0;
                default: ;
            endcase
        end
    end

    assign fifo_rd_o    = w_pop;
    assign core_blk_o   = r_blk;
    assign core_start_o = (r_state == S_START);
    assign core_init_o  = (r_state == S_START) && r_first;
    assign sts_busy_o   = (r_state == S_WAIT);
    assign sts_full_o   = (r_state == S_FULL);
    assign sts_valid_o  = r_valid;
    assign sts_err_o    = r_err;
    assign blk_cnt_o    = r_blk_cnt;
    assign word_cnt_o   = r_word_cnt;
endmodule
